// File: rtl/isi_capture_array_if.sv
// isi_capture_array_if: valid/ready beat bus carrying channel, interval and overflow (plus timestamp with ISI_TIMESTAMP_EN)
interface isi_capture_array_if #(
  parameter int BIT_ISI = 8,
  parameter int CH_W = 2
`ifdef ISI_TIMESTAMP_EN
  , parameter int BIT_TS = 16
`endif
);
  logic m_valid;
  logic m_ready;
  logic [CH_W-1:0] m_ch;
  logic [BIT_ISI-1:0] m_isi;
  logic m_of;
`ifdef ISI_TIMESTAMP_EN
  logic [BIT_TS-1:0] m_ts;
  modport master (output m_valid, m_ch, m_isi, m_of, m_ts, input m_ready);
  modport slave (input m_valid, m_ch, m_isi, m_of, m_ts, output m_ready);
`else
  modport master (output m_valid, m_ch, m_isi, m_of, input m_ready);
  modport slave (input m_valid, m_ch, m_isi, m_of, output m_ready);
`endif
endinterface

// File: rtl/isi_capture_array.sv
// isi_capture_array: multi-channel inter-spike-interval meter with round-robin merged output; ISI_TIMESTAMP_EN adds m_ts
module isi_capture_array #(
  parameter int BIT_ISI = 8,
  parameter int N_CH = 4,
  parameter int CH_W = 2,
  parameter int SAT = 1
`ifdef ISI_TIMESTAMP_EN
  , parameter int BIT_TS = 16
`endif
) (
  input  logic clk,
  input  logic clr,
  input  logic ce,
  input  logic [N_CH-1:0] spike,
  output logic [N_CH-1:0] armed,
  output logic [N_CH-1:0] drop,
  isi_capture_array_if.master m
);
  localparam logic [BIT_ISI-1:0] MAX = '1;
  logic [BIT_ISI-1:0] cnt_q [N_CH];
  logic [BIT_ISI-1:0] cnt_d [N_CH];
  logic [BIT_ISI-1:0] cap_q [N_CH];
  logic [BIT_ISI-1:0] cap_d [N_CH];
  logic [N_CH-1:0] of_q, of_d, armed_q, armed_d, pend_q, pend_d, capof_q, capof_d, drop_q, drop_d;
  logic [N_CH-1:0] take, keep, sp;
  logic v_q, v_d, mof_q, mof_d, found, load;
  logic [CH_W-1:0] ch_q, ch_d, rr_q, rr_d, gnt, idx;
  logic [BIT_ISI-1:0] isi_q, isi_d;
`ifdef ISI_TIMESTAMP_EN
  logic [BIT_TS-1:0] ts_q, ts_d, mts_q, mts_d;
  logic [BIT_TS-1:0] tscap_q [N_CH];
  logic [BIT_TS-1:0] tscap_d [N_CH];
`endif
  assign load = !v_q || m.m_ready;
  // first pending channel at or after the round-robin pointer
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = rr_q;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
      idx = (idx == CH_W'(N_CH - 1)) ? '0 : idx + CH_W'(1);
    end
    take = (found && load) ? (N_CH'(1) << gnt) : '0;
  end
  // per-channel counting, arming and capture; a load this cycle frees the slot for a new capture
  always_comb begin
    cnt_d = cnt_q;
    cap_d = cap_q;
    of_d = of_q;
    capof_d = capof_q;
    keep = pend_q & ~take;
    sp = spike & armed_q;
    armed_d = armed_q | spike;
    pend_d = keep | sp;
    drop_d = drop_q | (sp & keep);
    for (int i = 0; i < N_CH; i++) begin
      if (spike[i]) begin
        cnt_d[i] = (armed_q[i] && ce) ? BIT_ISI'(1) : '0;
        of_d[i] = 1'b0;
      end else if (armed_q[i] && ce) begin
        cnt_d[i] = (cnt_q[i] != MAX) ? cnt_q[i] + BIT_ISI'(1) : ((SAT != 0) ? MAX : '0);
        of_d[i] = of_q[i] | (cnt_q[i] == MAX);
      end
      if (sp[i] && !keep[i]) begin
        cap_d[i] = cnt_q[i];
        capof_d[i] = of_q[i];
      end
    end
  end
  // output register loads the granted capture when empty or on acceptance
  always_comb begin
    v_d = load ? found : v_q;
    ch_d = (load && found) ? gnt : ch_q;
    isi_d = (load && found) ? cap_q[gnt] : isi_q;
    mof_d = (load && found) ? capof_q[gnt] : mof_q;
    rr_d = !(load && found) ? rr_q : (gnt == CH_W'(N_CH - 1)) ? '0 : gnt + CH_W'(1);
  end
`ifdef ISI_TIMESTAMP_EN
  // free-running timestamp, captured alongside each interval and carried with the beat
  always_comb begin
    ts_d = ce ? ts_q + BIT_TS'(1) : ts_q;
    tscap_d = tscap_q;
    for (int i = 0; i < N_CH; i++) tscap_d[i] = (sp[i] && !keep[i]) ? ts_q : tscap_q[i];
    mts_d = (load && found) ? tscap_q[gnt] : mts_q;
  end
  // timestamp state
  always_ff @(posedge clk) begin
    if (clr) begin
      ts_q <= '0;
      mts_q <= '0;
      tscap_q <= '{default: '0};
    end else begin
      ts_q <= ts_d;
      mts_q <= mts_d;
      tscap_q <= tscap_d;
    end
  end
  assign m.m_ts = mts_q;
`endif
  // state update; clr overrides everything including a held beat
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '{default: '0};
      cap_q <= '{default: '0};
      of_q <= '0;
      capof_q <= '0;
      armed_q <= '0;
      pend_q <= '0;
      drop_q <= '0;
      v_q <= 1'b0;
      ch_q <= '0;
      isi_q <= '0;
      mof_q <= 1'b0;
      rr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cap_q <= cap_d;
      of_q <= of_d;
      capof_q <= capof_d;
      armed_q <= armed_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      v_q <= v_d;
      ch_q <= ch_d;
      isi_q <= isi_d;
      mof_q <= mof_d;
      rr_q <= rr_d;
    end
  end
  assign m.m_valid = v_q;
  assign m.m_ch = ch_q;
  assign m.m_isi = isi_q;
  assign m.m_of = mof_q;
  assign armed = armed_q;
  assign drop = drop_q;
endmodule

// File: tb/tb_isi_capture_array.sv
// tb_isi_capture_array: scoreboard bench for saturating and wrapping 4-bit, 4-channel instances
module tb_isi_capture_array;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic ce = 1'b0;
  logic mirror = 1'b0;
  logic [3:0] spike = '0;
  logic [3:0] spike_w = '0;
  logic [3:0] armed_s, drop_s, armed_w, drop_w;
  int checks = 0;
  int errors = 0;
  logic [6:0] q_s[$];
  logic [6:0] q_w[$];
  logic held = 1'b0;
  logic [6:0] hv, exp_s, exp_w;
  always #5 clk = ~clk;
  isi_capture_array_if #(.BIT_ISI(4), .CH_W(2)) bs ();
  isi_capture_array_if #(.BIT_ISI(4), .CH_W(2)) bw ();
  isi_capture_array #(.BIT_ISI(4), .N_CH(4), .CH_W(2), .SAT(1)) dut_s (
    .clk(clk), .clr(clr), .ce(ce), .spike(spike), .armed(armed_s), .drop(drop_s), .m(bs));
  isi_capture_array #(.BIT_ISI(4), .N_CH(4), .CH_W(2), .SAT(0)) dut_w (
    .clk(clk), .clr(clr), .ce(ce), .spike(spike_w), .armed(armed_w), .drop(drop_w), .m(bw));
  initial bw.m_ready = 1'b1;
  // monitor of the saturating instance: order, content and hold stability
  always @(negedge clk) begin
    if (clr) held = 1'b0;
    else begin
      if (held) begin
        checks++;
        if (!bs.m_valid || {bs.m_ch, bs.m_isi, bs.m_of} != hv) begin
          errors++;
          $display("FAIL hold_stable got v=%0b %h want v=1 %h", bs.m_valid, {bs.m_ch, bs.m_isi, bs.m_of}, hv);
        end
      end
      if (bs.m_valid && bs.m_ready) begin
        checks++;
        if (q_s.size() == 0) begin
          errors++;
          $display("FAIL sat_unexpected got ch=%0d isi=%0d of=%0b want no beat", bs.m_ch, bs.m_isi, bs.m_of);
        end else begin
          exp_s = q_s.pop_front();
          if ({bs.m_ch, bs.m_isi, bs.m_of} != exp_s) begin
            errors++;
            $display("FAIL sat_beat got ch=%0d isi=%0d of=%0b want ch=%0d isi=%0d of=%0b",
              bs.m_ch, bs.m_isi, bs.m_of, exp_s[6:5], exp_s[4:1], exp_s[0]);
          end
        end
      end
      held = bs.m_valid && !bs.m_ready;
      hv = {bs.m_ch, bs.m_isi, bs.m_of};
    end
  end
  // monitor of the wrapping instance
  always @(negedge clk) begin
    if (!clr && bw.m_valid) begin
      checks++;
      if (q_w.size() == 0) begin
        errors++;
        $display("FAIL wrap_unexpected got ch=%0d isi=%0d of=%0b want no beat", bw.m_ch, bw.m_isi, bw.m_of);
      end else begin
        exp_w = q_w.pop_front();
        if ({bw.m_ch, bw.m_isi, bw.m_of} != exp_w) begin
          errors++;
          $display("FAIL wrap_beat got ch=%0d isi=%0d of=%0b want ch=%0d isi=%0d of=%0b",
            bw.m_ch, bw.m_isi, bw.m_of, exp_w[6:5], exp_w[4:1], exp_w[0]);
        end
      end
    end
  end
  task automatic step(input logic c, input logic [3:0] s);
    ce = c;
    spike = s;
    spike_w = mirror ? s : 4'b0;
    @(posedge clk);
    #1;
    ce = 1'b0;
    spike = '0;
    spike_w = '0;
  endtask
  task automatic ticks(input int n);
    repeat (n) step(1'b1, 4'b0);
  endtask
  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask
  task automatic do_clr();
    clr = 1'b1;
    step(1'b0, 4'b0);
    clr = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q_s.size() != 0 || q_w.size() != 0) && n < 60) begin
      step(1'b0, 4'b0);
      n++;
    end
    check("drain_left", q_s.size() + q_w.size(), 0);
    repeat (3) step(1'b0, 4'b0);
  endtask
  initial begin
    bs.m_ready = 1'b1;
    repeat (2) step(1'b0, 4'b0);
    clr = 1'b0;
    check("rst_valid", int'(bs.m_valid), 0);
    check("rst_armed", int'(armed_s), 0);
    check("rst_drop", int'(drop_s), 0);
    // basic interval, first spike only arms
    do_clr();
    step(1'b0, 4'b0001);
    check("t1_armed", int'(armed_s), 1);
    ticks(5);
    q_s.push_back({2'd0, 4'd5, 1'b0});
    step(1'b0, 4'b0001);
    drain();
    // overflow: saturate vs wrap
    do_clr();
    mirror = 1'b1;
    step(1'b0, 4'b0100);
    ticks(20);
    q_s.push_back({2'd2, 4'd15, 1'b1});
    q_w.push_back({2'd2, 4'd4, 1'b1});
    step(1'b0, 4'b0100);
    mirror = 1'b0;
    drain();
    // round robin across simultaneous captures
    do_clr();
    step(1'b0, 4'b1111);
    ticks(3);
    for (int c = 0; c < 4; c++) q_s.push_back({2'(c), 4'd3, 1'b0});
    step(1'b0, 4'b1111);
    drain();
    ticks(3);
    q_s.push_back({2'd1, 4'd3, 1'b0});
    q_s.push_back({2'd3, 4'd3, 1'b0});
    step(1'b0, 4'b1010);
    drain();
    // backpressure: oldest kept, drop sticky
    do_clr();
    bs.m_ready = 1'b0;
    step(1'b0, 4'b0010);
    ticks(2);
    q_s.push_back({2'd1, 4'd2, 1'b0});
    step(1'b0, 4'b0010);
    ticks(4);
    q_s.push_back({2'd1, 4'd4, 1'b0});
    step(1'b0, 4'b0010);
    ticks(6);
    step(1'b0, 4'b0010);
    check("t4_drop", int'(drop_s), 2);
    check("t4_held_valid", int'(bs.m_valid), 1);
    check("t4_held_isi", int'(bs.m_isi), 2);
    bs.m_ready = 1'b1;
    drain();
    check("t4_drop_sticky", int'(drop_s), 2);
    // coincident tick belongs to the new interval
    do_clr();
    step(1'b0, 4'b0001);
    ticks(3);
    q_s.push_back({2'd0, 4'd3, 1'b0});
    step(1'b1, 4'b0001);
    ticks(2);
    q_s.push_back({2'd0, 4'd3, 1'b0});
    step(1'b0, 4'b0001);
    drain();
    // clr beats a held beat and pending captures
    do_clr();
    bs.m_ready = 1'b0;
    step(1'b0, 4'b0001);
    repeat (3) begin
      ticks(2);
      step(1'b0, 4'b0001);
    end
    step(1'b0, 4'b0);
    check("t6_pre_valid", int'(bs.m_valid), 1);
    check("t6_pre_drop", int'(drop_s), 1);
    do_clr();
    check("t6_clr_valid", int'(bs.m_valid), 0);
    check("t6_clr_armed", int'(armed_s), 0);
    check("t6_clr_drop", int'(drop_s), 0);
    bs.m_ready = 1'b1;
    step(1'b0, 4'b0001);
    check("t6_rearm", int'(armed_s), 1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
